// File: rtl/arbitro_pkg.sv
// Shared definitions for the arbitro output arbiter: system FSM state
// encodings and the destination-field width helper.
package arbitro_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_INIT   = 4'd1,
        ST_IDLE   = 4'd2,
        ST_ACTIVE = 4'd3,
        ST_ERROR  = 4'd4
    } sys_state_e;

    localparam int GRANT_CNT_W = 16;

    // Width of the destination field carried in the top bits of each word.
    function automatic int dest_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/arbitro_sel.sv
// Channel selector: grants the first requesting channel found when
// searching upward (with wrap) from the start pointer.
module arbitro_sel
    import arbitro_pkg::*;
#(
    parameter int NUM_CH = 4
) (
    input  logic [NUM_CH-1:0]         req,
    input  logic [dest_w(NUM_CH)-1:0] ptr,
    output logic [NUM_CH-1:0]         grant
);

    localparam int PTR_W = dest_w(NUM_CH);

    logic [PTR_W-1:0] idx;
    logic             found;

    // NUM_CH is a power of two, so truncating ptr+k gives the modulo wrap.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = PTR_W'(32'(ptr) + k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_param.sv
// Parameterised input-to-output queue arbiter; one word per cycle.
// Define ARBITRO_ROUND_ROBIN_EN for round-robin selection (default: fixed priority).
module arbitro_param
    import arbitro_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 10
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [3:0]               state,
    input  logic [NUM_CH-1:0]        in_empty,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        out_almost_full,
    output logic [NUM_CH-1:0]        in_pop,
    output logic [NUM_CH-1:0]        out_push,
    output logic [DATA_W-1:0]        out_data,
    output logic [2*NUM_CH-1:0]      empties,
    output logic [GRANT_CNT_W-1:0]   grant_cnt
);

    localparam int DEST_W = dest_w(NUM_CH);

    logic              active;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] req_en;
    logic [NUM_CH-1:0] grant;
    logic [DEST_W-1:0] ptr;
    logic [DEST_W-1:0] win_idx;
    logic [DEST_W-1:0] win_dest;
    logic [DATA_W-1:0] win_data;
    logic [NUM_CH-1:0] push_dec;
    logic              pop_any;

    assign active = (state == ST_ACTIVE);

    // A channel requests only if its head word's destination can accept it.
    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            req[i] = ~in_empty[i]
                   & ~out_almost_full[in_data[i*DATA_W + DATA_W - DEST_W +: DEST_W]];
        end
    end

    assign req_en = active ? req : '0;

    arbitro_sel #(
        .NUM_CH (NUM_CH)
    ) u_sel (
        .req   (req_en),
        .ptr   (ptr),
        .grant (grant)
    );

    assign in_pop  = reset_L ? grant : '0;
    assign pop_any = |in_pop;

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                win_idx  = DEST_W'(i);
                win_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign win_dest = win_data[DATA_W-1 -: DEST_W];
    assign push_dec = pop_any ? (NUM_CH'(1) << win_dest) : '0;

`ifdef ARBITRO_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            ptr <= '0;
        end else if (pop_any) begin
            ptr <= win_idx + DEST_W'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    // Upper half of empties doubles as the output-empty mirror state.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_push  <= '0;
            out_data  <= '0;
            grant_cnt <= '0;
            empties   <= '1;
        end else begin
            out_push  <= push_dec;
            if (pop_any) begin
                out_data <= win_data;
            end
            grant_cnt <= grant_cnt + GRANT_CNT_W'(pop_any);
            empties   <= {out_almost_full | (empties[2*NUM_CH-1:NUM_CH] & ~out_push),
                          in_empty};
        end
    end

`ifndef ARBITRO_ROUND_ROBIN_EN
    logic unused_win_idx;
    assign unused_win_idx = ^win_idx;
`endif

endmodule

// File: tb/tb_arbitro_param.sv
// Directed scoreboard bench for arbitro_param (NUM_CH=4, DATA_W=10).
module tb_arbitro_param;
  import arbitro_pkg::*;

  localparam int N = 4;
  localparam int W = 10;

  logic           clk = 1'b0;
  logic           reset_L;
  logic [3:0]     state;
  logic [N-1:0]   in_empty;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   out_almost_full;
  logic [N-1:0]   in_pop;
  logic [N-1:0]   out_push;
  logic [W-1:0]   out_data;
  logic [2*N-1:0] empties;
  logic [15:0]    grant_cnt;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  arbitro_param #(
    .NUM_CH (N),
    .DATA_W (W)
  ) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .state           (state),
    .in_empty        (in_empty),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .in_pop          (in_pop),
    .out_push        (out_push),
    .out_data        (out_data),
    .empties         (empties),
    .grant_cnt       (grant_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [N-1:0]   push;
    logic [W-1:0]   data;
    logic [2*N-1:0] empt;
    logic [15:0]    cnt;
    int unsigned    ptr;
  } exp_t;

  exp_t sb[$];

  logic [N-1:0]  m_push;
  logic [W-1:0]  m_data;
  logic [N-1:0]  m_mirror;
  logic [15:0]   m_cnt;
  int unsigned   m_ptr;

  task automatic model_reset();
    m_push   = '0;
    m_data   = '0;
    m_mirror = '1;
    m_cnt    = '0;
    m_ptr    = 0;
    sb.delete();
  endtask

  task automatic set_dests(input logic [1:0] d0, d1, d2, d3);
    in_data = {d3, 8'hA3, d2, 8'hA2, d1, 8'hA1, d0, 8'hA0};
  endtask

  // One clock: predict pop at the falling edge, check registered results after the rise.
  task automatic step(input bit do_chk);
    logic [N-1:0] req;
    logic [N-1:0] ep;
    logic [W-1:0] w;
    exp_t         e;
    int unsigned  idx;
    int unsigned  win;
    bit           found;
    @(negedge clk);
    for (int unsigned i = 0; i < N; i++) begin
      w      = in_data[i*W +: W];
      req[i] = !in_empty[i] && !out_almost_full[w[9:8]];
    end
    ep    = '0;
    found = 1'b0;
    win   = 0;
    if (state == ST_ACTIVE) begin
      for (int unsigned k = 0; k < N; k++) begin
`ifdef ARBITRO_ROUND_ROBIN_EN
        idx = (m_ptr + k) % N;
`else
        idx = k;
`endif
        if (!found && req[idx]) begin
          found = 1'b1;
          win   = idx;
        end
      end
    end
    if (found) ep[win] = 1'b1;
    if (do_chk) chk("in_pop", 32'(in_pop), 32'(ep));
    e.push = '0;
    e.data = m_data;
    e.ptr  = m_ptr;
    if (found) begin
      w = in_data[win*W +: W];
      e.push[w[9:8]] = 1'b1;
      e.data = w;
      e.ptr  = (win + 1) % N;
    end
    e.empt = {out_almost_full | (m_mirror & ~m_push), in_empty};
    e.cnt  = m_cnt + (found ? 16'd1 : 16'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e        = sb.pop_front();
    m_push   = e.push;
    m_data   = e.data;
    m_mirror = e.empt[2*N-1:N];
    m_cnt    = e.cnt;
    m_ptr    = e.ptr;
    if (do_chk) begin
      chk("out_push", 32'(out_push), 32'(e.push));
      chk("out_data", 32'(out_data), 32'(e.data));
      chk("empties", 32'(empties), 32'(e.empt));
      chk("grant_cnt", 32'(grant_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    reset_L         = 1'b0;
    state           = ST_ACTIVE;
    in_empty        = '0;
    out_almost_full = '0;
    set_dests(2'd2, 2'd2, 2'd2, 2'd2);
    model_reset();

    // Reset holds everything quiet even with requests pending.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_pop", 32'(in_pop), 32'h0);
    chk("rst_out_push", 32'(out_push), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h000);
    chk("rst_grant_cnt", 32'(grant_cnt), 32'h0000);
    chk("rst_empties", 32'(empties), 32'hFF);

    reset_L = 1'b1;
    repeat (5) step(1'b1);
    chk("cnt_after_5", 32'(grant_cnt), 32'd5);

    // Blocked destination is skipped, the next channel pops the same cycle.
    set_dests(2'd1, 2'd3, 2'd2, 2'd2);
    in_empty        = 4'b1100;
    out_almost_full = 4'b0010;
    repeat (2) step(1'b1);
    out_almost_full = 4'b1010;
    step(1'b1);
    out_almost_full = 4'b0000;
    in_empty        = 4'b1111;
    step(1'b1);

    // Leaving ACTIVE: pops stop, the registered push still lands once.
    set_dests(2'd2, 2'd2, 2'd2, 2'd2);
    in_empty = 4'b0000;
    state    = ST_ACTIVE;
    step(1'b1);
    state = ST_IDLE;
    repeat (2) step(1'b1);
    state = ST_ERROR;
    step(1'b1);

    // Reset asserted while a pop is in flight discards the pending push.
    state = ST_ACTIVE;
    step(1'b1);
    @(negedge clk);
    reset_L = 1'b0;
    #1;
    chk("midrst_in_pop", 32'(in_pop), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst_out_push", 32'(out_push), 32'h0);
    chk("midrst_grant_cnt", 32'(grant_cnt), 32'h0000);
    chk("midrst_empties", 32'(empties), 32'hFF);
    chk("midrst_out_data", 32'(out_data), 32'h000);
    model_reset();
    reset_L = 1'b1;

    // Counter wrap after 65535 grants.
    repeat (65535) step(1'b0);
    chk("cnt_pre_wrap", 32'(grant_cnt), 32'hFFFF);
    step(1'b1);
    chk("cnt_wrapped", 32'(grant_cnt), 32'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
